// File: rtl/ex_pkg.sv
// ex_pkg: shared op, ALU-control, state and control-bundle definitions for the execute controller
package ex_pkg;
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_ADDI = 3'd3,
    OP_LW   = 3'd4,
    OP_SW   = 3'd5,
    OP_BEQ  = 3'd6
  } op_t;
  localparam logic [1:0] ALU_CMP = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH} state_t;
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_ctrl;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
  } ex_ctl_t;
  localparam ex_ctl_t CTL_BUBBLE = '{1'b0, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0};
endpackage

// File: rtl/ex_decode.sv
// ex_decode: combinational op -> execute control bundle
//   op  in  3  decoded op
//   ctl out    control bundle (NOP and unknown ops decode to a bubble)
module ex_decode
  import ex_pkg::*;
(
  input  logic [2:0] op,
  output ex_ctl_t    ctl
);
  always_comb begin
    ctl           = CTL_BUBBLE;
    ctl.reg_dst   = op == OP_ADD || op == OP_SUB;
    ctl.alu_src   = op == OP_ADDI || op == OP_LW || op == OP_SW;
    ctl.alu_ctrl  = op == OP_SUB ? ALU_SUB : op == OP_BEQ ? ALU_CMP : ALU_ADD;
    ctl.reg_write = op == OP_ADD || op == OP_SUB || op == OP_ADDI || op == OP_LW;
    ctl.mem_read  = op == OP_LW;
    ctl.mem_write = op == OP_SW;
  end
endmodule

// File: rtl/ex_ctrl.sv
// ex_ctrl: ID/EX register, execute selects, load-use stall and branch flush control
//   clk, reset            clock and synchronous active-high reset
//   id_*                  decode-stage instruction and operands
//   alu_branch            branch outcome of the instruction now in EX
//   id_ready/flush_ifid/pc_src  combinational hazard/flush controls to fetch and decode
//   ex_*, reg_dst, alu_src, alu_ctrl  registered execute-stage state
//   stall_cnt, flush_cnt  saturating event counters
module ex_ctrl
  import ex_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [2:0]       id_op,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [31:0]      id_rd1,
  input  logic [31:0]      id_rd2,
  input  logic [31:0]      id_imm,
  input  logic [31:0]      id_pc4,
  input  logic             alu_branch,
  output logic             id_ready,
  output logic             flush_ifid,
  output logic             pc_src,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             reg_dst,
  output logic             alu_src,
  output logic [1:0]       alu_ctrl,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [31:0]      ex_rd1,
  output logic [31:0]      ex_rd2,
  output logic [31:0]      ex_imm,
  output logic [31:0]      ex_pc4,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  ex_ctl_t dec, ctl;
  op_t     ex_op;
  state_t  state, nxt;
  logic    hazard, taken, stall, bubble;
  ex_decode u_dec (.op(id_op), .ctl(dec));
  // alu_branch is stale for non-BEQ ops, so only a BEQ in EX may redirect fetch
  assign taken  = ex_valid && ex_op == OP_BEQ && alu_branch;
  // rt is only a source operand for ops that read two registers
  assign hazard = ex_valid && ex_mem_read && ex_rt != 5'd0 && id_valid &&
                  (ex_rt == id_rs || (ex_rt == id_rt &&
                   (id_op == OP_ADD || id_op == OP_SUB || id_op == OP_SW || id_op == OP_BEQ)));
  // a stall behind a taken branch is moot: that decode instruction is discarded
  assign stall      = hazard && !taken;
  assign id_ready   = !stall;
  assign flush_ifid = taken;
  assign pc_src     = taken;
  assign bubble     = !id_valid || hazard || taken;
  assign {reg_dst, alu_src, alu_ctrl, ex_reg_write, ex_mem_read, ex_mem_write} = ctl;
  // back-to-back stalls cannot occur; should one appear, fall back to RUN uncounted
  always_comb nxt = taken ? S_FLUSH : (stall && state != S_STALL) ? S_STALL : S_RUN;
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      ctl       <= CTL_BUBBLE;
      ex_op     <= OP_NOP;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      ex_rd1    <= '0;
      ex_rd2    <= '0;
      ex_imm    <= '0;
      ex_pc4    <= '0;
      state     <= S_RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      ex_valid  <= !bubble;
      ctl       <= bubble ? CTL_BUBBLE : dec;
      ex_op     <= bubble ? OP_NOP : op_t'(id_op);
      ex_rs     <= id_rs;
      ex_rt     <= id_rt;
      ex_rd     <= id_rd;
      ex_rd1    <= id_rd1;
      ex_rd2    <= id_rd2;
      ex_imm    <= id_imm;
      ex_pc4    <= id_pc4;
      state     <= nxt;
      stall_cnt <= stall_cnt + CNT_W'(nxt == S_STALL && !(&stall_cnt));
      flush_cnt <= flush_cnt + CNT_W'(nxt == S_FLUSH && !(&flush_cnt));
    end
  end
endmodule

// File: doc/ex_ctrl.md
# ex_ctrl

Execute-stage controller for the 5-stage pipeline. Owns the ID/EX pipeline register and drives the execute datapath selects (RegDst to Mux1, ALUSrc to Mux2, ALUctrl to alu). Sequences load-use stalls and branch-taken flushes, and keeps saturating stall/flush event counters. Sits between decode and the execute datapath; the fetch and decode stages take its stall/flush outputs.

## Interface
- CNT_W, 16, width of the event counters
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode slot holds an instruction
- id_op  in  3  decoded op (package `ex_pkg` encoding)
- id_rs, id_rt, id_rd  in  5 each  register fields
- id_rd1, id_rd2, id_imm  in  32 each  read data 1/2, sign-extended immediate
- id_pc4  in  32  PC+4 of the decode instruction
- alu_branch  in  1  alu out_branch for the current EX instruction
- id_ready  out  1  decode may advance (0 = hold IF/ID)
- flush_ifid  out  1  discard the IF/ID contents this edge
- pc_src  out  1  select the branch target in fetch
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered EX controls
- reg_dst, alu_src  out  1 each  Mux1/Mux2 selects
- alu_ctrl  out  2  00 = compare, 01 = add, 10 = sub
- ex_rs, ex_rt, ex_rd  out  5 each  registered fields
- ex_rd1, ex_rd2, ex_imm, ex_pc4  out  32 each  registered operands
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- Op decode (OP_NOP=0, OP_ADD, OP_SUB, OP_ADDI, OP_LW, OP_SW, OP_BEQ):
  - ADD/SUB: reg_dst=1, alu_src=0, reg_write=1.
  - ADDI/LW: reg_dst=0, alu_src=1, alu_ctrl=01, reg_write=1. LW also sets mem_read=1.
  - SW: alu_src=1, alu_ctrl=01, mem_write=1.
  - BEQ: alu_src=0, alu_ctrl=00, no write.
  - NOP and bubbles: all controls 0, alu_ctrl=01.
- Load-use hazard, combinational:
  - Condition: ex_valid & ex_mem_read & ex_rt≠0 & id_valid & (ex_rt==id_rs | (ex_rt==id_rt & id_op∈{ADD,SUB,SW,BEQ})).
  - Effect: id_ready=0, and the next edge loads a bubble into EX.
- Branch taken, combinational: taken = ex_valid & op_ex==BEQ & alu_branch.
  - alu_branch is ignored for non-BEQ ops, because alu holds its old value on mismatch.
  - taken drives pc_src=1 and flush_ifid=1.
  - The next edge loads a bubble into EX, and the decode instruction is dropped.
- Priority: branch flush over load-use stall. A stall caused by a flushed instruction is not counted.
- FSM with states RUN, STALL, FLUSH. The state records last cycle's action and feeds the counters; it does not gate the datapath.
  - RUN→STALL on a hazard.
  - RUN/STALL→FLUSH on taken.
  - STALL/FLUSH→RUN when neither condition holds.
  - STALL→STALL is impossible (the hazard clears once LW moves to MEM). It is still coded safe: return to RUN.
- Counters increment once per cycle in which the hazard, or taken, is applied. They saturate at all-ones.

## Timing
- ID→EX latency is 1 cycle. Every ex_* output, reg_dst, alu_src and alu_ctrl is registered.
- id_ready, flush_ifid and pc_src are combinational from registered state plus inputs, with no dependency on id_ready itself.
- A load-use stall costs exactly 1 bubble. The held instruction enters EX one cycle later.
- A taken branch costs exactly 1 bubble plus the discarded IF/ID slot.
- Reset, synchronous, all registers:
  - all outputs 0, except alu_ctrl=01;
  - state=RUN;
  - counters=0.
- Reset asserted mid-stall or mid-flush overrides both. The first post-reset cycle is RUN with ex_valid=0.
- id_valid=0 loads a bubble and does not count as a stall.

## Structure
- Package `ex_pkg` holds:
  - the op enum (3 bits);
  - the ALUctrl constants ALU_CMP=2'b00, ALU_ADD=2'b01, ALU_SUB=2'b10;
  - the state enum;
  - a packed `ex_ctl_t` struct with reg_dst, alu_src, alu_ctrl, reg_write, mem_read, mem_write.
- One sub-module, `ex_decode`: combinational id_op → `ex_ctl_t`. The controller registers its output or a zero bubble.

## Test plan
- Reset, then ADD (rs=1, rt=2, rd=3): after 1 edge, ex_valid=1, reg_dst=1, alu_src=0, alu_ctrl=01, ex_rd=3.
- LW rt=5, then ADD rs=5: id_ready=0 for 1 cycle; EX bubble; ADD in EX on the following edge; stall_cnt=1.
- LW rt=0, then ADD rs=0: no stall; stall_cnt stays 0.
- BEQ in EX with alu_branch=1: pc_src=1 and flush_ifid=1 that cycle; next EX is a bubble; flush_cnt=1.
- ADD in EX with alu_branch stuck at 1: pc_src=0, no flush.
- Load-use hazard and taken branch in the same cycle: flush only; flush_cnt+1, stall_cnt unchanged.
- Reset asserted during STALL: next cycle state=RUN, ex_valid=0, counters=0.
- Force 2^CNT_W+3 stalls: stall_cnt holds at all-ones.
